// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN pooling front end.
// The window bank is indexed [channel][slot], and slot 0 holds the oldest sample.
package cnn_pkg;

   localparam int CH  = 16;
   localparam int WIN = 5;
   localparam int DW  = 8;
   localparam int CW  = (WIN > 1) ? $clog2(WIN) : 1;

   typedef logic [DW-1:0]     sample_t;
   typedef sample_t [CH-1:0]  chan_vec_t;
   typedef sample_t [WIN-1:0] window_t;
   typedef window_t [CH-1:0]  win_bank_t;

   localparam sample_t   PAD      = '0;
   localparam win_bank_t PAD_BANK = {(CH*WIN){PAD}};

   // Returns 1 when a fill count sits on the last slot of a window.
   function automatic logic at_last_slot(input logic [CW-1:0] cnt);
      return cnt == CW'(WIN - 1);
   endfunction

endpackage

// File: rtl/pool_win_fill.sv
// Fill buffer and slot counter for one pooling window.
// When a beat completes the window, this block presents the finished bank combinationally.
module pool_win_fill
   import cnn_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            accept,
   input  chan_vec_t       in_data,
   input  logic            in_last,
   output logic            last_slot,
   output logic            done,
   output win_bank_t       done_bank
);

   logic [CW-1:0] cnt;
   win_bank_t     fill_buf;

   assign last_slot = at_last_slot(cnt);
   assign done      = accept & (last_slot | in_last);

   // The completing beat is merged in here, so the output register can load the whole window in one edge.
   always_comb begin
      done_bank = fill_buf;
      for (int c = 0; c < CH; c++) begin
         for (int j = 0; j < WIN; j++) begin
            if (CW'(j) == cnt)
               done_bank[c][j] = in_data[c];
            else if (CW'(j) > cnt)
               done_bank[c][j] = PAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         fill_buf <= PAD_BANK;
      end else if (accept) begin
         if (done) begin
            cnt      <= '0;
            fill_buf <= PAD_BANK;
         end else begin
            cnt <= cnt + 1'b1;
            for (int c = 0; c < CH; c++) begin
               for (int j = 0; j < WIN; j++) begin
                  if (CW'(j) == cnt)
                     fill_buf[c][j] <= in_data[c];
               end
            end
         end
      end
   end

endmodule

// File: rtl/pool_window_gather.sv
// Gathers WIN consecutive 16-channel samples into non-overlapping windows for the max-pool stage.
// The output register is double-buffered against the fill buffer, so partial fills continue while the consumer stalls.
module pool_window_gather
   import cnn_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  chan_vec_t  in_data,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output win_bank_t  out_win,
   output logic       out_last,
   output logic [7:0] win_count
);

   logic      accept;
   logic      drain;
   logic      last_slot;
   logic      done;
   win_bank_t done_bank;

   // Input is blocked only when this beat would complete a window and the output register has nowhere to go.
   assign in_ready = !(out_valid & !out_ready & (last_slot | in_last));
   assign accept   = in_valid & in_ready;
   assign drain    = out_valid & out_ready;

   pool_win_fill u_fill (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept),
      .in_data   (in_data),
      .in_last   (in_last),
      .last_slot (last_slot),
      .done      (done),
      .done_bank (done_bank)
   );

   // A completing beat reloads the register even while it drains, so consecutive windows have no bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_win   <= PAD_BANK;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (done) begin
         out_win   <= done_bank;
         out_valid <= 1'b1;
         out_last  <= in_last;
      end else if (drain) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         win_count <= 8'd0;
      else if (drain) begin
         if (out_last)
            win_count <= 8'd0;
         else if (win_count != 8'hFF)
            win_count <= win_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_pool_window_gather.sv
// Scoreboard bench for pool_window_gather. It compares the DUT against a queue-based reference model of the windowing rules.
module tb_pool_window_gather;
   import cnn_pkg::*;

   localparam int BW = $bits(win_bank_t);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   chan_vec_t  in_data = '0;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   win_bank_t  out_win;
   logic       out_last;
   logic [7:0] win_count;

   pool_window_gather dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_win   (out_win),
      .out_last  (out_last),
      .win_count (win_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: samples collected so far, windows awaiting the consumer, and the expected window counter.
   chan_vec_t part_q[$];
   win_bank_t exp_q[$];
   bit        exp_last_q[$];
   int        wc = 0;
   int        acc_count = 0;
   int        pops = 0;
   int        stalls = 0;
   int        ready_mode = 0;
   bit        prev_hold = 0;
   win_bank_t prev_win;
   logic      prev_last;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: predicts in_ready and out_valid from model state, scores drained windows, and records accepted beats.
   always @(negedge clk) begin
      if (!rst) begin
         prev_hold = 0;
      end else begin
         check("in_ready", in_ready,
               !(exp_q.size() > 0 && !out_ready && (part_q.size() == WIN - 1 || in_last)));
         check("out_valid", out_valid, exp_q.size() > 0);
         if (prev_hold) begin
            check("hold_win", out_win, prev_win);
            check("hold_last", out_last, prev_last);
         end
         prev_hold = out_valid && !out_ready;
         prev_win  = out_win;
         prev_last = out_last;
         if (out_valid && out_ready && exp_q.size() > 0) begin
            check("win_count", win_count, wc);
            check("out_win", out_win, exp_q[0]);
            check("out_last", out_last, exp_last_q[0]);
            wc = exp_last_q[0] ? 0 : (wc == 255 ? 255 : wc + 1);
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            pops++;
         end
         if (in_valid && !in_ready) stalls++;
         if (in_valid && in_ready) begin
            part_q.push_back(in_data);
            acc_count++;
            if (part_q.size() == WIN || in_last) begin
               win_bank_t w;
               for (int c = 0; c < CH; c++)
                  for (int j = 0; j < WIN; j++)
                     w[c][j] = (j < part_q.size()) ? part_q[j][c] : PAD;
               exp_q.push_back(w);
               exp_last_q.push_back(in_last);
               part_q.delete();
            end
         end
      end
   end

   task automatic applyStimulus(input chan_vec_t d, input logic last);
      int start;
      bit ok;
      start    = acc_count;
      ok       = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (acc_count != start) begin
            ok = 1;
            break;
         end
      end
      #1;
      if (!ok) check("accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic go_idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 1'b0, 1'b1);
      go_idle(2);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst      = 1'b0;
      part_q.delete();
      exp_q.delete();
      exp_last_q.delete();
      wc = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic checkOutput_reset();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_win_count", win_count, 8'd0);
      check("rst_out_win", out_win, PAD_BANK);
      check("rst_in_ready", in_ready, 1'b1);
   endtask

   function automatic chan_vec_t rand_vec();
      chan_vec_t d;
      for (int c = 0; c < CH; c++) d[c] = sample_t'($urandom);
      return d;
   endfunction

   function automatic chan_vec_t ramp_vec(input int k);
      chan_vec_t d;
      for (int c = 0; c < CH; c++) d[c] = sample_t'(10 * c + k);
      return d;
   endfunction

   initial begin
      chan_vec_t d;
      window_t   w3;
      int        p0;
      int        s0;

      #2;
      do_reset();
      checkOutput_reset();

      // Ten ramp beats produce two windows, and out_valid appears one cycle after beats 5 and 10.
      ready_mode = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(ramp_vec(k), 1'b0);
         check("t1_valid_latency", out_valid, (k == 4 || k == 9));
         if (k == 4) begin
            for (int j = 0; j < WIN; j++) w3[j] = sample_t'(30 + j);
            check("t1_win0_ch3", out_win[3], w3);
         end
      end
      wait_idle();
      check("t1_win_count", win_count, 8'd2);

      // Seven beats that end in a record boundary: the second window is padded and clears win_count.
      for (int k = 0; k < 7; k++) applyStimulus(rand_vec(), k == 6);
      wait_idle();
      check("t2_win_count", win_count, 8'd0);

      // The consumer stalls while five windows of input are offered.
      ready_mode = 1;
      s0 = stalls;
      fork
         for (int k = 0; k < 25; k++) applyStimulus(rand_vec(), 1'b0);
         begin
            repeat (40) @(posedge clk);
            ready_mode = 0;
         end
      join
      wait_idle();
      check("t3_stall_seen", stalls > s0, 1'b1);

      // Continuous traffic: each window must be replaced in the same cycle it is drained.
      for (int k = 0; k < 20; k++) applyStimulus(rand_vec(), 1'b0);
      wait_idle();

      // Reset in the middle of a window discards the partial data.
      for (int k = 0; k < 3; k++) applyStimulus(rand_vec(), 1'b0);
      go_idle(1);
      do_reset();
      checkOutput_reset();
      p0 = pops;
      for (int c = 0; c < CH; c++) d[c] = 8'hFF;
      for (int k = 0; k < 5; k++) applyStimulus(d, 1'b0);
      wait_idle();
      check("t5_one_window", pops - p0, 1);

      // A single-beat record.
      for (int c = 0; c < CH; c++) d[c] = 8'h80;
      applyStimulus(d, 1'b1);
      wait_idle();
      check("t6_win_count", win_count, 8'd0);

      // win_count saturates after 255 windows and then clears on a record end.
      for (int k = 0; k < 260 * WIN; k++) applyStimulus(rand_vec(), 1'b0);
      wait_idle();
      check("sat_win_count", win_count, 8'd255);
      applyStimulus(rand_vec(), 1'b1);
      wait_idle();
      check("sat_clear", win_count, 8'd0);

      // Random gaps, random back-pressure and random record ends.
      ready_mode = 2;
      for (int k = 0; k < 200; k++) begin
         applyStimulus(rand_vec(), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) go_idle(1);
      end
      ready_mode = 0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pool_window_gather.md
Name: pool_window_gather

Overview:
- Upstream feeder for the 16-channel, 5-input max-pooling layer.
- Accepts the conv/ReLU stage's output stream, one 16-channel sample per accepted beat, and groups WIN consecutive samples per channel into non-overlapping windows (stride = WIN).
- Presents each complete window as a packed per-channel array with a valid/ready handshake; out_valid drives the pooling layer's en.

Parameters:
- CH, 16, number of channels
- WIN, 5, window length and stride (samples per pool)
- DW, 8, sample width (unsigned, post-ReLU)
- PAD, 0, value written into unfilled slots of a truncated final window

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  CH x DW (packed [CH-1:0][DW-1:0])  one sample for every channel
- in_last  in  1  marks the final sample of a record
- out_valid  out  1  window available; connects to the pooling layer's en
- out_ready  in  1  consumer takes the window
- out_win  out  CH x WIN x DW (packed [CH-1:0][WIN-1:0][DW-1:0])  slot 0 = oldest sample
- out_last  out  1  window contains the record's final sample
- win_count  out  8  windows emitted since the last record end; saturates at 255

Behaviour:
- Reset (rst=0, async): fill counter=0, fill buffer=PAD, out_win=PAD, out_valid=0, out_last=0, win_count=0. in_ready=1 on the first cycle after release.
- Structure: fill buffer (CH x WIN) plus output register (CH x WIN), i.e. double-buffered.
- Input accept: in_valid & in_ready. The sample is written into fill slot[cnt] for every channel, then cnt increments.
- Window completes on the accept where cnt==WIN-1, or where in_last=1 (any cnt).
- On completion:
  - The fill buffer transfers to out_win, with slots above the final written slot forced to PAD.
  - out_valid=1 the next cycle.
  - out_last=in_last of the completing beat.
  - cnt returns to 0 and the fill buffer is cleared to PAD.
  - Latency from the completing accept to out_valid is 1 cycle.
- Output handshake: out_win, out_valid and out_last hold stable until out_valid & out_ready.
  - On that handshake, win_count increments (saturating).
  - If out_last=1, win_count clears to 0 instead.
- in_ready = !(out_valid & !out_ready & completing_beat_possible). Equivalently, in_ready drops only when cnt==WIN-1 and the output register is occupied and not being drained this cycle. Partial fills continue during stall.
- Simultaneous drain and complete: when out_valid & out_ready coincide with a completing accept, the new window loads the same cycle and out_valid stays 1. This gives back-to-back windows with no bubble.
- Stall on a truncated window: in_last arriving while the output is occupied and not draining is not accepted. in_ready is 0 in that case as well, so the in_ready rule extends to: cnt==WIN-1 OR in_last.
- in_valid=0: no state change except the output handshake.
- Reset mid-window: the partial window is discarded and no window is emitted.
- Width: no arithmetic on data; counters are $clog2(WIN) bits for cnt and 8 bits saturating for win_count.

Decomposition:
- Shared package cnn_pkg holds:
  - constants CH, WIN, DW, PAD
  - typedef sample_t = logic [DW-1:0]
  - typedef chan_vec_t = sample_t [CH-1:0]
  - typedef window_t = sample_t [WIN-1:0]
  - typedef win_bank_t = window_t [CH-1:0]
- One natural sub-module: pool_win_fill (the per-record fill buffer plus counter, with a completion strobe). The top adds the output register, handshake and win_count.

Test Plan:
- Reset, then 10 beats with out_ready=1 held high. Channel c, beat k gets value 10*c+k. Expected: two windows. Window 0 channel 3 = {30,31,32,33,34}; window 1 channel 3 = {35..39}; out_valid pulses 1 cycle after beats 5 and 10; win_count=2.
- 7 beats with in_last on beat 7, PAD=0. Expected: second window slot0..1 = beats 6..7, slots 2..4 = 0, out_last=1; win_count returns to 0 after the handshake.
- out_ready=0 while 5 windows' worth of input is offered. Expected: the first window is held stable; in_ready=0 once the next fill reaches cnt==4; the stalled beat is not lost; 5 windows emerge in order after out_ready=1.
- Drain and complete in the same cycle, with continuous in_valid and out_ready=1. Expected: out_valid stays 1 across consecutive windows with 0 bubble cycles; each window's data is correct.
- Assert rst low after 3 beats, release, then send 5 beats of 0xFF. Expected: exactly one window, all slots 0xFF; the earlier partial data never appears.
- Single beat with in_last, value 0x80 on all channels. Expected: window slot0=0x80, slots 1..4=PAD, out_last=1.
